// File: rtl/delay_line_prober_if.sv
// Handshake and probe/echo signals between delay_line_prober and the logic that drives or observes it.
interface delay_line_prober_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             echo_in;
    logic             probe_out;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] latency;

    modport master (
        output start,
        output echo_in,
        input  probe_out,
        input  busy,
        input  done,
        input  timeout,
        input  latency
    );

    modport slave (
        input  start,
        input  echo_in,
        output probe_out,
        output busy,
        output done,
        output timeout,
        output latency
    );
endinterface

// File: rtl/delay_line_prober.sv
// Launches a probe pulse into a serial path, measures echo latency in cycles, or reports a timeout.
module delay_line_prober #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 200,
    parameter int unsigned PULSE_LEN = 1
) (
    input  logic                clk,
    input  logic                rst,
    delay_line_prober_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StQuiet, StPulse, StWait, StReport} state_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] QuietLast  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PulseLast  = CNT_W'(PULSE_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic             probe_q, probe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latency_d = latency_q;
        probe_d   = probe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StQuiet;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            // A stale high on the path must drain before the probe goes out.
            StQuiet: begin
                if (!bus.echo_in) begin
                    state_d = StPulse;
                    probe_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == QuietLast) begin
                    state_d   = StReport;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    latency_d = '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // cnt_q equals k-1 at edge Ek after the probe edge; echo is checked before the limit.
            StPulse, StWait: begin
                if (bus.echo_in) begin
                    state_d   = StReport;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    probe_d   = 1'b0;
                    timeout_d = 1'b0;
                    latency_d = cnt_q;
                end else if (cnt_q == TimeoutCnt) begin
                    state_d   = StReport;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    probe_d   = 1'b0;
                    timeout_d = 1'b1;
                    latency_d = '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == StPulse && cnt_q == PulseLast) begin
                        state_d = StWait;
                        probe_d = 1'b0;
                    end
                end
            end

            StReport: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            latency_q <= '0;
            probe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latency_q <= latency_d;
            probe_q   <= probe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.probe_out = probe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.latency   = latency_q;

endmodule

// File: tb/tb_delay_line_prober.sv
// Randomised bench for delay_line_prober: models the path as a variable delay line with
// stale-high and stuck-low overrides, and predicts each result from closed-form timing rules.
module tb_delay_line_prober;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TIMEOUT   = 20;
    localparam int unsigned PULSE_LEN = 3;

    logic clk;
    logic rst;

    delay_line_prober_if #(.CNT_W(CNT_W)) bus ();

    delay_line_prober #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .PULSE_LEN(PULSE_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Path model: delay line of loop_d cycles (0 = direct wire) with overrides.
    logic [31:0] hist;
    int          loop_d;
    logic        force_hi;
    logic        stuck0;
    logic        hist_clr;
    logic        echo;

    always @(posedge clk) begin
        if (rst || hist_clr) hist <= '0;
        else                 hist <= {hist[30:0], bus.probe_out};
    end

    always_comb begin
        echo = 1'b0;
        if (force_hi)         echo = 1'b1;
        else if (stuck0)      echo = 1'b0;
        else if (loop_d == 0) echo = bus.probe_out;
        else                  echo = hist[loop_d-1];
    end

    assign bus.echo_in = echo;

    int n_checks;
    int n_fail;
    int prev_lat;
    int prev_to;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // d: path delay, h: sampled-high cycles forced after start, stuck: path never echoes,
    // spam: extra start pulses while busy and in the done cycle.
    task automatic run_txn(input int d, input int h, input bit stuck, input bit spam);
        int done_exp, lat_exp, to_exp, probe_exp, e0;
        int done_at, n_done, n_probe, n_busy;

        if (h >= int'(TIMEOUT)) begin
            done_exp  = TIMEOUT;
            lat_exp   = 255;
            to_exp    = 1;
            probe_exp = 0;
        end else begin
            e0 = 1 + h;
            if (!stuck && d <= int'(TIMEOUT)) begin
                done_exp  = e0 + d + 1;
                lat_exp   = d;
                to_exp    = 0;
                probe_exp = (d + 1 < int'(PULSE_LEN)) ? d + 1 : PULSE_LEN;
            end else begin
                done_exp  = e0 + TIMEOUT + 1;
                lat_exp   = 255;
                to_exp    = 1;
                probe_exp = PULSE_LEN;
            end
        end

        @(negedge clk);
        bus.start = 1'b1;
        force_hi  = (h > 0);
        stuck0    = stuck;
        loop_d    = d;
        hist_clr  = 1'b1;
        done_at   = -1;
        n_done    = 0;
        n_probe   = 0;
        n_busy    = 0;

        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            hist_clr = 1'b0;
            force_hi = (n < h);
            if (n == 0) begin
                check_eq("lat_held_at_start", int'(bus.latency), prev_lat);
                check_eq("to_held_at_start", int'(bus.timeout), prev_to);
            end
            if (bus.probe_out) n_probe++;
            if (bus.busy)      n_busy++;
            if (bus.done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = n;
                    check_eq("latency", int'(bus.latency), lat_exp);
                    check_eq("timeout", int'(bus.timeout), to_exp);
                end
            end
            bus.start = spam && (done_at < 0 || n == done_at) && ($urandom_range(0, 2) == 0);
            if (done_at >= 0 && n >= done_at + 3) break;
        end
        bus.start = 1'b0;

        check_eq("done_cycle", done_at, done_exp);
        check_eq("done_count", n_done, 1);
        check_eq("probe_cycles", n_probe, probe_exp);
        check_eq("busy_cycles", n_busy, done_exp);
        check_eq("lat_hold_after", int'(bus.latency), lat_exp);
        prev_lat = lat_exp;
        prev_to  = to_exp;
    endtask

    task automatic reset_mid_op();
        int n_done;
        n_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        force_hi  = 1'b0;
        stuck0    = 1'b0;
        loop_d    = 4;
        hist_clr  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        hist_clr  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_probe", int'(bus.probe_out), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);
        check_eq("rst_latency", int'(bus.latency), 0);
        check_eq("rst_timeout", int'(bus.timeout), 0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        check_eq("rst_quiet_after", n_done, 0);
        prev_lat = 0;
        prev_to  = 0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        prev_lat  = 0;
        prev_to   = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        force_hi  = 1'b0;
        stuck0    = 1'b0;
        hist_clr  = 1'b0;
        loop_d    = 4;
        repeat (3) @(negedge clk);
        check_eq("reset_probe", int'(bus.probe_out), 0);
        check_eq("reset_busy", int'(bus.busy), 0);
        check_eq("reset_done", int'(bus.done), 0);
        check_eq("reset_timeout", int'(bus.timeout), 0);
        check_eq("reset_latency", int'(bus.latency), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(4, 0, 1'b0, 1'b0);
        run_txn(0, 0, 1'b0, 1'b0);
        run_txn(0, 0, 1'b1, 1'b0);
        run_txn(4, 5, 1'b0, 1'b0);
        run_txn(4, 25, 1'b0, 1'b0);
        run_txn(TIMEOUT, 0, 1'b0, 1'b0);
        run_txn(TIMEOUT + 1, 0, 1'b0, 1'b0);
        run_txn(1, 0, 1'b0, 1'b0);
        run_txn(2, 0, 1'b0, 1'b1);
        run_txn(4, 0, 1'b0, 1'b1);
        reset_mid_op();
        run_txn(4, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int d, h;
            d = $urandom_range(0, 24);
            h = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 25) : $urandom_range(0, 3);
            run_txn(d, h, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
